// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the handshaked data memory.
//   memState_t  : handshake FSM states (IDLE, WAIT, RESP)
//   BYTES/OFF_W/IDX_W : lane count, byte-offset width and word-index width
//                       for the default 32-bit x 256-word configuration
//   accessFault : flags a misaligned or out-of-range byte address
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } memState_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 256;
    localparam int BYTES          = DATA_W_DEFAULT / 8;
    localparam int OFF_W          = $clog2(BYTES);
    localparam int IDX_W          = $clog2(DEPTH_DEFAULT);

    // The range check is done on the full-width word index, before it is
    // truncated to the storage index width, so high address bits cannot
    // alias back into the array.
    function automatic logic accessFault(input logic [63:0] byteAddr,
                                         input int          offW,
                                         input int          depth);
        logic [63:0] offMask;
        logic [63:0] wordIdx;
        offMask = (64'd1 << offW) - 64'd1;
        wordIdx = byteAddr >> offW;
        return ((byteAddr & offMask) != 64'd0) || (wordIdx >= 64'(depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word storage with byte-lane write enables.
//   i_clk   : rising-edge clock
//   i_we    : write strobe for the addressed word
//   i_be    : per-byte write enables
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : combinational read of the addressed word
// Contents are deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [$clog2(DEPTH)-1:0]   i_idx,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Only lanes with their enable set are written; the rest keep their value.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_hs.sv
// mem_hs: byte-addressed data memory with valid/ready request and response.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_wdata, i_req_be
//                         : request channel (accepted only in IDLE)
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err
//                         : response channel, held stable until taken
// Stores commit at the accept edge; loads sample the word at the accept edge.
// The response appears LATENCY edges after accept.
module mem_hs
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_write,
    input  logic [ADDR_W-1:0]    i_req_addr,
    input  logic [DATA_W-1:0]    i_req_wdata,
    input  logic [DATA_W/8-1:0]  i_req_be,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATA_W-1:0]    o_rsp_rdata,
    output logic                 o_rsp_err
);

    localparam int LANES    = DATA_W / 8;
    localparam int OFFSET_W = $clog2(LANES);
    localparam int INDEX_W  = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(LATENCY + 1);

    // Reject configurations the handshake cannot support.
    generate
        if (LATENCY < 1) begin : g_badLatency
            $error("mem_hs: LATENCY must be at least 1");
        end
        if ((DATA_W % 8) != 0 || (LANES & (LANES - 1)) != 0) begin : g_badWidth
            $error("mem_hs: DATA_W must be 8 times a power of two");
        end
    endgenerate

    memState_t            r_state;
    memState_t            w_nextState;
    logic [CNT_W-1:0]     r_count;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_fault;
    logic                 w_write;
    logic [INDEX_W-1:0]   w_idx;
    logic [DATA_W-1:0]    w_arrayRdata;

    assign w_accept = (r_state == IDLE) && i_req_valid;
    assign w_fault  = accessFault(64'(i_req_addr), OFFSET_W, DEPTH);
    assign w_idx    = INDEX_W'(i_req_addr >> OFFSET_W);
    assign w_write  = w_accept && i_req_write && !w_fault;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_write),
        .i_be    (i_req_be),
        .i_idx   (w_idx),
        .i_wdata (i_req_wdata),
        .o_rdata (w_arrayRdata)
    );

    // State register; reset drops any pending response immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: LATENCY==1 skips WAIT entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_count == CNT_W'(1)) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Latency counter: loaded with LATENCY-1 at accept, counts down in WAIT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= (LATENCY > 1) ? CNT_W'(LATENCY - 1) : '0;
        end else if (r_state == WAIT) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Response payload captured at accept and cleared at handoff.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (!i_req_write && !w_fault) ? w_arrayRdata : '0;
            r_err   <= w_fault;
        end else if (r_state == RESP && i_rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    // Outputs decoded from state; payload only visible while in RESP.
    always_comb begin
        o_req_ready = (r_state == IDLE);
        o_rsp_valid = (r_state == RESP);
        o_rsp_rdata = (r_state == RESP) ? r_rdata : '0;
        o_rsp_err   = (r_state == RESP) && r_err;
    end

endmodule

// File: tb/tb_mem_hs.sv
// tb_mem_hs: scoreboard bench for mem_hs. Main instance uses LATENCY=3, a
// second instance uses LATENCY=1. Expected responses are queued at issue
// time and popped by per-instance monitors on each response handoff.
module tb_mem_hs;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } expect_t;

    logic        clock = 1'b0;
    logic        reset;

    logic        reqValid, reqReady, reqWrite, rspValid, rspReady, rspErr;
    logic [31:0] reqAddr, reqWdata, rspRdata;
    logic [3:0]  reqBe;

    logic        reqValidL1, reqReadyL1, reqWriteL1, rspValidL1, rspReadyL1, rspErrL1;
    logic [31:0] reqAddrL1, reqWdataL1, rspRdataL1;
    logic [3:0]  reqBeL1;

    expect_t     expQ[$];
    expect_t     expQL1[$];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clock = ~clock;

    mem_hs #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(3)) dut (
        .i_clk       (clock),
        .i_reset     (reset),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_write (reqWrite),
        .i_req_addr  (reqAddr),
        .i_req_wdata (reqWdata),
        .i_req_be    (reqBe),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_rdata (rspRdata),
        .o_rsp_err   (rspErr)
    );

    mem_hs #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(1)) dutL1 (
        .i_clk       (clock),
        .i_reset     (reset),
        .i_req_valid (reqValidL1),
        .o_req_ready (reqReadyL1),
        .i_req_write (reqWriteL1),
        .i_req_addr  (reqAddrL1),
        .i_req_wdata (reqWdataL1),
        .i_req_be    (reqBeL1),
        .o_rsp_valid (rspValidL1),
        .i_rsp_ready (rspReadyL1),
        .o_rsp_rdata (rspRdataL1),
        .o_rsp_err   (rspErrL1)
    );

    // One comparison: counts it and reports a mismatch on its own line.
    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor for the main instance: every handoff must match the next expectation.
    always @(negedge clock) begin
        expect_t e;
        if (!reset && rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rsp: got rdata %h err %b, expected no response", rspRdata, rspErr);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_rdata"}, rspRdata, e.rdata);
                checkOutput({e.name, "_err"}, 32'(rspErr), 32'(e.err));
            end
        end
    end

    // Monitor for the LATENCY=1 instance.
    always @(negedge clock) begin
        expect_t e;
        if (!reset && rspValidL1 && rspReadyL1) begin
            if (expQL1.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rsp_l1: got rdata %h err %b, expected no response", rspRdataL1, rspErrL1);
            end else begin
                e = expQL1.pop_front();
                checkOutput({e.name, "_rdata"}, rspRdataL1, e.rdata);
                checkOutput({e.name, "_err"}, 32'(rspErrL1), 32'(e.err));
            end
        end
    end

    task automatic pushExp(input logic [31:0] d, input logic er, input string nm);
        expect_t e;
        e.rdata = d;
        e.err   = er;
        e.name  = nm;
        expQ.push_back(e);
    endtask

    // Bounded wait for the main instance to become ready.
    task automatic waitReady(input string nm);
        int n = 0;
        while (!reqReady && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!reqReady) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: got req_ready 0, expected 1 within 50 cycles", nm);
        end
    endtask

    // Issue one request on the main instance and wait for it to complete.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input logic [31:0] expD,
                                 input logic expE, input string nm);
        waitReady({nm, "_issue"});
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr  = a;
        reqWdata = d;
        reqBe    = be;
        pushExp(expD, expE, nm);
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        waitReady({nm, "_done"});
    endtask

    // Issue one request on the LATENCY=1 instance, checking its timing.
    task automatic applyStimulusL1(input logic w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be, input logic [31:0] expD,
                                   input logic expE, input string nm);
        expect_t e;
        int n = 0;
        while (!reqReadyL1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        reqValidL1 = 1'b1;
        reqWriteL1 = w;
        reqAddrL1  = a;
        reqWdataL1 = d;
        reqBeL1    = be;
        e.rdata = expD;
        e.err   = expE;
        e.name  = nm;
        expQL1.push_back(e);
        @(posedge clock);
        #1;
        reqValidL1 = 1'b0;
        checkOutput({nm, "_valid_lat1"}, 32'(rspValidL1), 32'd1);
        @(posedge clock);
        #1;
        checkOutput({nm, "_ready_back"}, 32'(reqReadyL1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        reqValid   = 1'b0;
        reqWrite   = 1'b0;
        reqAddr    = '0;
        reqWdata   = '0;
        reqBe      = '0;
        rspReady   = 1'b1;
        reqValidL1 = 1'b0;
        reqWriteL1 = 1'b0;
        reqAddrL1  = '0;
        reqWdataL1 = '0;
        reqBeL1    = '0;
        rspReadyL1 = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_rsp_rdata", rspRdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic stores and loads
        applyStimulus(1, 32'd16, 32'h12345678, 4'hF, 32'h0, 0, "st16");
        applyStimulus(1, 32'd24, 32'h89abcdef, 4'hF, 32'h0, 0, "st24");
        applyStimulus(1, 32'd20, 32'h00000000, 4'hF, 32'h0, 0, "st20");
        applyStimulus(0, 32'd16, 32'h0, 4'h0, 32'h12345678, 0, "ld16");
        applyStimulus(0, 32'd20, 32'h0, 4'h0, 32'h00000000, 0, "ld20");
        applyStimulus(0, 32'd24, 32'h0, 4'h0, 32'h89abcdef, 0, "ld24");

        // Byte lanes
        applyStimulus(1, 32'd32, 32'hFFFFFFFF, 4'hF, 32'h0, 0, "st32_all");
        applyStimulus(1, 32'd32, 32'h000000AA, 4'b0001, 32'h0, 0, "st32_lane0");
        applyStimulus(0, 32'd32, 32'h0, 4'h0, 32'hFFFFFFAA, 0, "ld32_a");
        applyStimulus(1, 32'd32, 32'h11223344, 4'b0000, 32'h0, 0, "st32_be0");
        applyStimulus(0, 32'd32, 32'h0, 4'h0, 32'hFFFFFFAA, 0, "ld32_b");

        // Faults and range boundary
        applyStimulus(1, 32'd0, 32'hA5A5A5A5, 4'hF, 32'h0, 0, "st0");
        applyStimulus(0, 32'd18, 32'h0, 4'h0, 32'h0, 1, "ld18_misaligned");
        applyStimulus(1, 32'd1024, 32'h55555555, 4'hF, 32'h0, 1, "st1024_range");
        applyStimulus(1, 32'd2, 32'h77777777, 4'hF, 32'h0, 1, "st2_misaligned");
        applyStimulus(0, 32'd0, 32'h0, 4'h0, 32'hA5A5A5A5, 0, "ld0");
        applyStimulus(1, 32'd1020, 32'h0BADF00D, 4'hF, 32'h0, 0, "st1020_last");
        applyStimulus(0, 32'd1020, 32'h0, 4'h0, 32'h0BADF00D, 0, "ld1020_last");
        applyStimulus(0, 32'd1023, 32'h0, 4'h0, 32'h0, 1, "ld1023_misaligned");

        // Latency 3 timing and back-pressure
        waitReady("bp");
        rspReady = 1'b0;
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 32'd16;
        reqBe    = 4'h0;
        pushExp(32'h12345678, 0, "bp_ld16");
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        checkOutput("lat3_edge1_valid", 32'(rspValid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("lat3_edge2_valid", 32'(rspValid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("lat3_edge3_valid", 32'(rspValid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", 32'(rspValid), 32'd1);
            checkOutput("bp_hold_rdata", rspRdata, 32'h12345678);
            checkOutput("bp_hold_err", 32'(rspErr), 32'd0);
            checkOutput("bp_hold_req_ready", 32'(reqReady), 32'd0);
            @(posedge clock);
            #1;
        end
        rspReady = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("bp_release_req_ready", 32'(reqReady), 32'd1);
        checkOutput("bp_release_rsp_valid", 32'(rspValid), 32'd0);

        // Latency 1 instance
        applyStimulusL1(1, 32'd8, 32'hDEADBEEF, 4'hF, 32'h0, 0, "l1_st8");
        applyStimulusL1(1, 32'd8, 32'h00112200, 4'b0110, 32'h0, 0, "l1_st8_mid");
        applyStimulusL1(0, 32'd8, 32'h0, 4'h0, 32'hDE1122EF, 0, "l1_ld8");

        // Reset during WAIT drops the response but keeps the committed store
        waitReady("rst_mid");
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'd40;
        reqWdata = 32'hCAFEBABE;
        reqBe    = 4'hF;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        checkOutput("rst_mid_busy", 32'(reqReady), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_mid_req_ready", 32'(reqReady), 32'd1);
        #1;
        reset = 1'b0;
        applyStimulus(0, 32'd40, 32'h0, 4'h0, 32'hCAFEBABE, 0, "ld40_after_rst");

        // Requests during WAIT are ignored
        waitReady("ign");
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 32'd20;
        pushExp(32'h0, 0, "ign_ld20");
        @(posedge clock);
        #1;
        reqAddr = 32'd16;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        applyStimulus(0, 32'd16, 32'h0, 4'h0, 32'h12345678, 0, "ld16_after_ign");

        repeat (3) @(posedge clock);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("queue_drained_l1", 32'(expQL1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_hs.md
Name: mem_hs

Overview:
Parametrised, byte-addressed data memory with a valid/ready request/response handshake. It succeeds the plain single-cycle `mem` data memory and adds:
- configurable data width, depth and read latency
- byte-lane write enables
- misaligned and out-of-range fault reporting
- response back-pressure

It sits between the datapath load/store stage and the backing word storage.

Parameters:
DATA_W, 32, word width in bits; a multiple of 8, and DATA_W/8 a power of two.
DEPTH, 256, number of words stored.
ADDR_W, 32, byte-address width.
LATENCY, 2, edges from request accept to rsp_valid; must be at least 1 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data
req_be  input  DATA_W/8  byte-lane write enables (ignored on loads)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_rdata  output  DATA_W  load data (0 for stores and faults)
rsp_err  output  1  access faulted

Behaviour:
- Reset values:
  - Asynchronous reset forces state IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; latency counter=0.
  - Storage contents are NOT cleared; unwritten words read as X in simulation.
- States: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - rsp_valid=1 only in RESP.
- Accept: the rising edge with state==IDLE and req_valid=1.
  - Request fields are sampled at this edge.
  - Address fault: req_addr not word-aligned (low log2(DATA_W/8) bits nonzero) → err=1.
  - Range fault: word index req_addr>>log2(DATA_W/8) >= DEPTH → err=1.
- Store with no fault: at the accept edge, each lane i with req_be[i]=1 is updated with req_wdata[8i+7:8i]; other lanes are unchanged.
  - be=0 is a legal no-op that still responds with err=0.
- Load with no fault: the word is captured at the accept edge.
  - A load immediately following a store to the same word returns the updated data, since the store committed at its own accept edge.
- Faulted access: no storage update; rdata=0.
- Timing:
  - LATENCY=1: IDLE→RESP at the accept edge.
  - LATENCY>1: IDLE→WAIT, with the counter loaded to LATENCY-1.
  - WAIT: the counter decrements each edge; when it reaches 1, move to RESP.
  - Net effect: rsp_valid rises exactly LATENCY edges after the accept edge.
- RESP:
  - rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - At the edge with rsp_ready=1, go to IDLE, clear rsp_valid, zero rsp_rdata/rsp_err.
  - req_ready returns the cycle after handoff; there is no same-edge accept of a new request.
- Simultaneous events: req_valid asserted during WAIT/RESP is ignored (not queued); the requester must hold it until req_ready.
- Reset mid-operation: the pending response is dropped and the block is in IDLE immediately. A store already committed at its accept edge remains in storage.
- Arithmetic: counter width clog2(LATENCY+1); word index truncated to clog2(DEPTH) bits only after the range check.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - localparams BYTES=DATA_W/8, OFF_W=clog2(BYTES), IDX_W=clog2(DEPTH)
  - a helper function computing the aligned/in-range fault
- One sub-module mem_array: a synchronous single-port word store with a byte-enable write. It holds the storage only; mem_hs keeps the handshake and fault logic.

Test Plan:
1. Store 0x12345678 @16 (be=4'hF), store 0x89abcdef @24, store 0x0 @20, then load 16, 20, 24 → rsp_rdata 12345678, 00000000, 89abcdef; rsp_err=0 on all.
2. Byte lanes: store 0xFFFFFFFF @32, store 0x000000AA @32 with be=4'b0001, load 32 → FFFFFFAA; store with be=0 returns err=0 and the word is unchanged.
3. Faults: load @18 (misaligned) → err=1, rdata=0. Store @1024 with DEPTH=256 → err=1, and a following load @0 shows word 0 unchanged.
4. Latency/back-pressure:
   - LATENCY=3: rsp_valid rises exactly 3 edges after accept.
   - Hold rsp_ready=0 for 5 cycles: rdata/err are stable and req_ready=0 throughout.
   - Release: req_ready is high the next cycle.
   - Repeat with LATENCY=1: rsp_valid is high one edge after accept.
5. Reset mid-operation: accept store 0xCAFEBABE @40, pulse reset in WAIT → rsp_valid=0 and req_ready=1 immediately; a later load @40 returns CAFEBABE.
6. Ignored requests: drive req_valid with a load @16 during WAIT → no second response; a load @16 issued after handoff completes normally.
